// File: rtl/sw_s2p_reader.sv
`default_nettype none
// ============================================================================
// Module      : sw_s2p_reader
// Description : Serial-to-parallel reader for a parallel-in/serial-out chain
//               (74HC165 style). On Start the chain is parallel-loaded, then
//               DATA_BITS bits are shifted in MSB-first and the captured word
//               is presented on P_Data together with a one-cycle done pulse.
// Options     : S2P_DEBOUNCE_EN - P_Data only updates when two consecutive
//               frames are identical.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_s2p_reader #(
  parameter int DATA_BITS       = 16,
  parameter int DATA_COUNT_BITS = 4,
  parameter int CLK_DIV         = 2,
  parameter int INVERT          = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Start,
  input  logic                 sin,
  output logic                 s_clk,
  output logic                 s_load_n,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] P_Data
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]           DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DATA_COUNT_BITS-1:0] BIT_LAST = DATA_COUNT_BITS'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [DIV_W-1:0]           div_cnt;
  logic [DIV_W-1:0]           div_cnt_nxt;
  logic                       phase;        // 0: s_clk low half, 1: s_clk high half
  logic                       phase_nxt;
  logic [DATA_COUNT_BITS-1:0] bit_cnt;
  logic [DATA_COUNT_BITS-1:0] bit_cnt_nxt;
  logic                       period_end;
  logic                       sample_now;
  logic [DATA_BITS-1:0]       sreg;
  logic [DATA_BITS-1:0]       word;
  logic                       accept;
  logic                       s_clk_nxt;
  logic                       s_load_n_nxt;
  logic                       busy_nxt;
  logic                       done_nxt;

  // Last cycle of a full 2*CLK_DIV period (used for both LOAD and each bit)
  assign period_end = phase && (div_cnt == DIV_LAST);
  // First cycle of the high half: this edge also raises the registered s_clk,
  // so sin still holds the chain output from before the shift
  assign sample_now = (state == SHIFT) && phase && (div_cnt == '0);
  assign word       = (INVERT != 0) ? ~sreg : sreg;

`ifdef S2P_DEBOUNCE_EN
  logic [DATA_BITS-1:0] prev;

  // Remember the last frame so a new word is only accepted when it repeats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else if (state == DONE) begin
      prev <= word;
    end
  end

  assign accept = (word == prev);
`else
  assign accept = 1'b1;
`endif

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      phase   <= phase_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Next-state, counter and output-register decode
  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    phase_nxt    = phase;
    bit_cnt_nxt  = bit_cnt;
    s_clk_nxt    = (state == SHIFT) && phase;
    s_load_n_nxt = (state != LOAD);
    busy_nxt     = (state != IDLE);
    done_nxt     = (state == DONE);

    if ((state == LOAD) || (state == SHIFT)) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt_nxt = '0;
        phase_nxt   = ~phase;
      end else begin
        div_cnt_nxt = div_cnt + DIV_W'(1);
      end
    end

    case (state)
      IDLE: begin
        div_cnt_nxt = '0;
        phase_nxt   = 1'b0;
        bit_cnt_nxt = '0;
        if (Start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (period_end) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (period_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_nxt   = DONE;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + DATA_COUNT_BITS'(1);
          end
        end
      end
      DONE: begin
        state_nxt   = IDLE;
        div_cnt_nxt = '0;
        phase_nxt   = 1'b0;
        bit_cnt_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift register: MSB-first capture on each rising s_clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (sample_now) begin
      sreg <= {sreg[DATA_BITS-2:0], sin};
    end
  end

  // Registered outputs; P_Data only changes on a completed frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_clk    <= 1'b0;
      s_load_n <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      P_Data   <= '0;
    end else begin
      s_clk    <= s_clk_nxt;
      s_load_n <= s_load_n_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      if ((state == DONE) && accept) begin
        P_Data <= word;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sw_s2p_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_s2p_reader
// Description : Directed self-checking bench for sw_s2p_reader with a
//               behavioural 74HC165 chain per instance. Honors
//               S2P_DEBOUNCE_EN for the debounce expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_s2p_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic sin_a, sin_b, sin_c;
  logic sclk_a, sclk_b, sclk_c;
  logic sload_a, sload_b, sload_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic [15:0] pdata_a, pdata_b;
  logic [7:0]  pdata_c;

  logic [15:0] pat_a = '0, chain_a = '0, pat_b = '0, chain_b = '0;
  logic [7:0]  pat_c = '0, chain_c = '0;
  logic        sclkd_a = 1'b0, sclkd_b = 1'b0, sclkd_c = 1'b0;

  int nd_a = 0, nl_a = 0, nr_a = 0;
  int nb_b = 0;
  int nl_c = 0, nr_c = 0;

  int n_tests = 0;
  int n_fail  = 0;

  assign sin_a = chain_a[15];
  assign sin_b = chain_b[15];
  assign sin_c = chain_c[7];

  always #5 clk = ~clk;

  sw_s2p_reader u_a (
    .clk(clk), .rst_n(rst_n), .Start(start_a), .sin(sin_a),
    .s_clk(sclk_a), .s_load_n(sload_a), .busy(busy_a), .done(done_a), .P_Data(pdata_a)
  );

  sw_s2p_reader #(.INVERT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .Start(start_b), .sin(sin_b),
    .s_clk(sclk_b), .s_load_n(sload_b), .busy(busy_b), .done(done_b), .P_Data(pdata_b)
  );

  sw_s2p_reader #(.DATA_BITS(8), .DATA_COUNT_BITS(3), .CLK_DIV(1)) u_c (
    .clk(clk), .rst_n(rst_n), .Start(start_c), .sin(sin_c),
    .s_clk(sclk_c), .s_load_n(sload_c), .busy(busy_c), .done(done_c), .P_Data(pdata_c)
  );

  // Chain model A plus event counters
  always @(posedge clk) begin
    if (!sload_a) chain_a <= pat_a;
    else if (sclk_a && !sclkd_a) chain_a <= {chain_a[14:0], 1'b0};
    sclkd_a <= sclk_a;
    if (done_a) nd_a <= nd_a + 1;
    if (!sload_a) nl_a <= nl_a + 1;
    if (sclk_a && !sclkd_a) nr_a <= nr_a + 1;
  end

  // Chain model B plus busy-cycle counter
  always @(posedge clk) begin
    if (!sload_b) chain_b <= pat_b;
    else if (sclk_b && !sclkd_b) chain_b <= {chain_b[14:0], 1'b0};
    sclkd_b <= sclk_b;
    if (busy_b) nb_b <= nb_b + 1;
  end

  // Chain model C plus event counters
  always @(posedge clk) begin
    if (!sload_c) chain_c <= pat_c;
    else if (sclk_c && !sclkd_c) chain_c <= {chain_c[6:0], 1'b0};
    sclkd_c <= sclk_c;
    if (!sload_c) nl_c <= nl_c + 1;
    if (sclk_c && !sclkd_c) nr_c <= nr_c + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse Start for one edge (E0) and count cycles until done is seen
  task automatic frame_a(input logic [15:0] pat, output int lat);
    pat_a = pat;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic frame_b(input logic [15:0] pat, output int lat);
    pat_b = pat;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic frame_c(input logic [7:0] pat, output int lat);
    pat_c = pat;
    @(posedge clk); #1 start_c = 1'b1;
    @(posedge clk); #1 start_c = 1'b0;
    lat = 0;
    while (!done_c && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int l0, r0, d0, b0, k, cyc;
    int t [3];

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_clk",    32'(sclk_a),  32'd0);
    check("rst_s_load_n", 32'(sload_a), 32'd1);
    check("rst_busy",     32'(busy_a),  32'd0);
    check("rst_done",     32'(done_a),  32'd0);
    check("rst_p_data",   32'(pdata_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // T1: basic frame
    l0 = nl_a; r0 = nr_a; d0 = nd_a;
    frame_a(16'hA5C3, lat);
    check("t1_latency", 32'(lat), 32'd69);
    check("t1_p_data",  32'(pdata_a), 32'hA5C3);
    repeat (3) @(posedge clk);
    #1;
    check("t1_load_cycles", 32'(nl_a - l0), 32'd4);
    check("t1_sclk_rises",  32'(nr_a - r0), 32'd16);
    check("t1_done_count",  32'(nd_a - d0), 32'd1);
    check("t1_done_low",    32'(done_a), 32'd0);

    // T2: inverted output, busy duration
    b0 = nb_b;
    frame_b(16'h00FF, lat);
    check("t2_latency", 32'(lat), 32'd69);
    check("t2_p_data",  32'(pdata_b), 32'hFF00);
    repeat (3) @(posedge clk);
    #1;
    check("t2_busy_cycles", 32'(nb_b - b0), 32'd69);
    check("t2_busy_low",    32'(busy_b), 32'd0);

    // T6: CLK_DIV=1, DATA_BITS=8
    l0 = nl_c; r0 = nr_c;
    frame_c(8'h81, lat);
    check("t6_latency", 32'(lat), 32'd19);
    check("t6_p_data",  32'(pdata_c), 32'h81);
    repeat (3) @(posedge clk);
    #1;
    check("t6_sclk_rises",  32'(nr_c - r0), 32'd8);
    check("t6_load_cycles", 32'(nl_c - l0), 32'd2);

    // T4a: Start re-pulsed mid-frame is ignored
    d0 = nd_a;
    pat_a = 16'h3C5A;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (20) @(posedge clk);
    #1 start_a = 1'b1;
    check("t4_busy_mid", 32'(busy_a), 32'd1);
    @(posedge clk); #1 start_a = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check("t4_single_done", 32'(nd_a - d0), 32'd1);
    check("t4_p_data",      32'(pdata_a), 32'h3C5A);

    // T4b: Start held high -> back-to-back frames 70 cycles apart
    d0 = nd_a;
    pat_a = 16'h0F0F;
    start_a = 1'b1;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (done_a) begin
        t[k] = cyc;
        k++;
      end
    end
    start_a = 1'b0;
    check("t4_held_frames", 32'(k), 32'd3);
    if (k == 3) begin
      check("t4_spacing_1", 32'(t[1] - t[0]), 32'd70);
      check("t4_spacing_2", 32'(t[2] - t[1]), 32'd70);
    end
    repeat (150) @(posedge clk);
    #1;
    check("t4_held_done_count", 32'(nd_a - d0), 32'd3);
    check("t4_held_p_data",     32'(pdata_a), 32'h0F0F);

    // T3: reset during bit 7 aborts the frame
    pat_a = 16'hFFFF;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (34) @(posedge clk);
    #1;
    check("t3_busy_before", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t3_s_clk",    32'(sclk_a),  32'd0);
    check("t3_s_load_n", 32'(sload_a), 32'd1);
    check("t3_busy",     32'(busy_a),  32'd0);
    check("t3_done",     32'(done_a),  32'd0);
    check("t3_p_data",   32'(pdata_a), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    d0 = nd_a;
    repeat (100) @(posedge clk);
    #1;
    check("t3_no_done",        32'(nd_a - d0), 32'd0);
    check("t3_p_data_after",   32'(pdata_a), 32'd0);

    // T5: debounce behaviour (or plain follow without the option)
    frame_a(16'h1234, lat);
    check("t5_lat_1", 32'(lat), 32'd69);
`ifdef S2P_DEBOUNCE_EN
    check("t5_p_data_1", 32'(pdata_a), 32'h0000);
`else
    check("t5_p_data_1", 32'(pdata_a), 32'h1234);
`endif
    frame_a(16'h1235, lat);
    check("t5_lat_2", 32'(lat), 32'd69);
`ifdef S2P_DEBOUNCE_EN
    check("t5_p_data_2", 32'(pdata_a), 32'h0000);
`else
    check("t5_p_data_2", 32'(pdata_a), 32'h1235);
`endif
    frame_a(16'h1235, lat);
    check("t5_lat_3",    32'(lat), 32'd69);
    check("t5_p_data_3", 32'(pdata_a), 32'h1235);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
